// File: rtl/gcd_scheduler.sv
// Round-robin front end that shares one gcd engine among N requesters.
// Accepts one job at a time, runs it on the engine and returns a tagged, cycle-counted response.
module gcd_scheduler #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int CW = 32,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IW-1:0]  rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic [CW-1:0]  rsp_cycles,
  output logic           eng_start,
  output logic [W-1:0]   eng_a,
  output logic [W-1:0]   eng_b,
  input  logic [W-1:0]   eng_result,
  input  logic           eng_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_next;
  logic [IW-1:0] ptr, ptr_next;
  logic [IW-1:0] grant_id;
  logic          grant_found;
  logic [IW:0]   scan_idx;
  logic          accept;
  logic [CW-1:0] counter, counter_inc;

  // Rotating-priority search: first valid requester at or after ptr, wrapping mod N.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(N)) scan_idx = scan_idx - (IW+1)'(N);
      if (!grant_found && req_valid[scan_idx[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx[IW-1:0];
      end
    end
  end

  assign ptr_next    = (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;
  assign counter_inc = (counter == '1) ? counter : counter + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    eng_start  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so req_ready drops asynchronously even with requests pending.
        if (grant_found && !reset) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_next          = ISSUE;
        end
      end
      ISSUE: begin
        eng_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (eng_done) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      eng_a      <= '0;
      eng_b      <= '0;
      rsp_id     <= '0;
      counter    <= '0;
      rsp_result <= '0;
      rsp_cycles <= '0;
    end else begin
      // Operands go straight to the engine ports and stay there until the next acceptance.
      if (accept) begin
        eng_a  <= req_a[grant_id*W +: W];
        eng_b  <= req_b[grant_id*W +: W];
        rsp_id <= grant_id;
        ptr    <= ptr_next;
      end
      if (state == ISSUE) counter <= '0;
      if (state == WAIT) begin
        counter <= counter_inc;
        if (eng_done) begin
          rsp_result <= eng_result;
          rsp_cycles <= counter_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Self-checking bench for gcd_scheduler with a subtractive gcd engine model attached.
// Expected results come from Euclid arithmetic; expected cycle counts from the subtract-step count.
module tb_gcd_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic [CW-1:0]  rsp_cycles;
  logic           eng_start;
  logic [W-1:0]   eng_a, eng_b, eng_result;
  logic           eng_done;

  int n_pass  = 0;
  int n_total = 0;

  gcd_scheduler #(.N(N), .W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_cycles(rsp_cycles),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_result(eng_result), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  // Subtractive gcd engine: one subtract per cycle, one more cycle to notice a zero operand.
  logic [W-1:0] ea, eb;
  logic         busy;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0; eng_done <= 1'b0; eng_result <= '0; ea <= '0; eb <= '0;
    end else if (eng_start && !busy) begin
      ea <= eng_a; eb <= eng_b; busy <= 1'b1; eng_done <= 1'b0;
    end else if (busy) begin
      if (ea == 0 || eb == 0) begin
        eng_result <= ea | eb; eng_done <= 1'b1; busy <= 1'b0;
      end else if (ea >= eb) ea <= ea - eb;
      else                   eb <= eb - ea;
    end
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Subtract steps equal the sum of Euclid quotients.
  function automatic int ref_steps(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a, y = b, t;
    int s = 0;
    while (y != 0) begin s += int'(x / y); t = x % y; x = y; y = t; end
    return s;
  endfunction

  function automatic int ref_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
    int c = ref_steps(a, b) + 2;
    return (c > CMAX) ? CMAX : c;
  endfunction

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id]    = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_total++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_cycles, eng_start, eng_a, eng_b} !== '0)
      $display("FAIL %s: req_ready=%b rsp_valid=%b rsp_id=%0d rsp_result=%0d rsp_cycles=%0d eng_start=%b eng_a=%0d eng_b=%0d, all required 0",
               tag, req_ready, rsp_valid, rsp_id, rsp_result, rsp_cycles, eng_start, eng_a, eng_b);
    else n_pass++;
  endtask

  // Full job with rsp_ready assumed high: acceptance, single start pulse, latency and response fields.
  task automatic run_job(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, starts, busy_ready, wait_c;
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[id] = 1'b1;
    set_req(id, a, b);
    #1;
    wait_c = 0;
    while (!req_ready[id] && wait_c < 100) begin @(negedge clk); #1; wait_c++; end
    n_total++;
    if (req_ready !== onehot) $display("FAIL accept_%0d: req_ready=%b required %b", id, req_ready, onehot);
    else n_pass++;
    @(negedge clk);
    req_valid[id] = 1'b0;
    n_total++;
    if (eng_start !== 1'b1 || eng_a !== a || eng_b !== b)
      $display("FAIL issue_%0d: eng_start=%b eng_a=%0d eng_b=%0d required 1 %0d %0d", id, eng_start, eng_a, eng_b, a, b);
    else n_pass++;
    lat = 1; starts = 0; busy_ready = 0;
    while (!rsp_valid && lat < 3000) begin
      @(negedge clk); #1;
      lat++;
      if (eng_start) starts++;
      if (req_ready != 0) busy_ready++;
    end
    n_total++;
    if (lat !== ref_steps(a, b) + 4 || starts !== 0 || busy_ready !== 0)
      $display("FAIL latency_%0d(%0d,%0d): latency=%0d extra_starts=%0d busy_ready=%0d required %0d 0 0",
               id, a, b, lat, starts, busy_ready, ref_steps(a, b) + 4);
    else n_pass++;
    n_total++;
    if (rsp_id !== 2'(id) || rsp_result !== ref_gcd(a, b) || rsp_cycles !== CW'(ref_cycles(a, b)))
      $display("FAIL response_%0d(%0d,%0d): id=%0d result=%0d cycles=%0d required %0d %0d %0d",
               id, a, b, rsp_id, rsp_result, rsp_cycles, id, ref_gcd(a, b), ref_cycles(a, b));
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL resp_one_cycle_%0d: rsp_valid=%b required 0", id, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    req_valid = '1;
    #3;
    check_idle_outputs("reset_state");
    repeat (2) @(negedge clk);
    req_valid = '0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    run_job(2, 32'd12, 32'd8);
  endtask

  task automatic test_zero_operands;
    run_job(0, 32'd0, 32'd9);
    run_job(1, 32'd7, 32'd0);
    run_job(3, 32'd0, 32'd0);
  endtask

  task automatic test_random;
    for (int j = 0; j < 10; j++) begin
      logic [W-1:0] a, b;
      a = (j % 4 == 3) ? 32'd0 : W'($urandom_range(1, 60));
      b = W'($urandom_range(0, 60));
      run_job(int'($urandom_range(0, N - 1)), a, b);
    end
  endtask

  // All requesters valid from reset: grants rotate 0,1,2,3,... and jobs go back to back.
  task automatic test_fairness;
    logic [W-1:0] fa [N];
    logic [W-1:0] fb [N];
    int grants, rsps, last_id, last_acc, cyc;
    fa = '{32'd12, 32'd18, 32'd35, 32'd9};
    fb = '{32'd8,  32'd27, 32'd14, 32'd0};
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, fa[i], fb[i]);
    @(negedge clk);
    reset = 1'b0;
    #1;
    grants = 0; rsps = 0; last_id = 0; last_acc = 0; cyc = 0;
    while ((grants < 8 || rsps < 8) && cyc < 500) begin
      if (req_ready != 0 && grants < 8) begin
        n_total++;
        if (req_ready !== N'(1 << (grants % N)))
          $display("FAIL rr_grant_%0d: req_ready=%b required %b", grants, req_ready, N'(1 << (grants % N)));
        else n_pass++;
        if (grants > 0) begin
          n_total++;
          if (cyc - last_acc !== ref_steps(fa[last_id], fb[last_id]) + 5)
            $display("FAIL rr_spacing_%0d: spacing=%0d required %0d", grants, cyc - last_acc,
                     ref_steps(fa[last_id], fb[last_id]) + 5);
          else n_pass++;
        end
        last_id = grants % N; last_acc = cyc; grants++;
      end
      if (rsp_valid && rsps < 8) begin
        n_total++;
        if (rsp_id !== 2'(last_id) || rsp_result !== ref_gcd(fa[last_id], fb[last_id]))
          $display("FAIL rr_response_%0d: id=%0d result=%0d required %0d %0d", rsps, rsp_id, rsp_result,
                   last_id, ref_gcd(fa[last_id], fb[last_id]));
        else n_pass++;
        rsps++;
      end
      @(negedge clk); #1;
      cyc++;
    end
    n_total++;
    if (grants !== 8 || rsps !== 8) $display("FAIL rr_progress: grants=%0d responses=%0d required 8 8", grants, rsps);
    else n_pass++;
    req_valid = '0;
    while (rsp_valid || dut.state != 0) @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    rsp_ready = 1'b0;
    set_req(1, 32'd18, 32'd12);
    #1;
    while (!req_ready[1]) @(negedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(3, 32'd25, 32'd10);
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    for (int c = 0; c < 10; c++) begin
      #1;
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== ref_gcd(32'd18, 32'd12) ||
          rsp_cycles !== CW'(ref_cycles(32'd18, 32'd12)) || req_ready !== '0)
        $display("FAIL hold_%0d: valid=%b id=%0d result=%0d cycles=%0d req_ready=%b required 1 1 %0d %0d 0000",
                 c, rsp_valid, rsp_id, rsp_result, rsp_cycles, req_ready,
                 ref_gcd(32'd18, 32'd12), ref_cycles(32'd18, 32'd12));
      else n_pass++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000)
      $display("FAIL next_accept: rsp_valid=%b req_ready=%b required 0 1000", rsp_valid, req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid[3] = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    n_total++;
    if (rsp_id !== 2'd3 || rsp_result !== ref_gcd(32'd25, 32'd10))
      $display("FAIL pending_job: id=%0d result=%0d required 3 %0d", rsp_id, rsp_result, ref_gcd(32'd25, 32'd10));
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    set_req(0, 32'd1000, 32'd1);
    #1;
    while (!req_ready[0]) @(negedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (20) @(negedge clk);
    set_req(1, 32'd6, 32'd4);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("reset_mid_wait");
    @(negedge clk);
    reset = 1'b0;
    run_job(1, 32'd6, 32'd4);
  endtask

  task automatic test_long_job;
    run_job(2, 32'd1000, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_zero_operands();
    test_random();
    test_fairness();
    test_backpressure();
    test_reset_mid_wait();
    test_long_job();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
